// File: rtl/write_stage_if.sv
// rtl/write_stage_if.sv - execute-to-write handshake interface
//
// Carries one instruction result from the execute stage to the write stage.
// The write stage drives hold back to stall execute while a store is pending.
//   pc                    instruction address of the retiring instruction
//   adjustment            store address offset added to the base register
//   destination_value     register write value, or store data
//   destination           target register index (may exceed the file depth)
//   flags                 condition flags produced by the instruction
//   destination_is_memory 1 = store to memory, 0 = register write
//   has_flushed           1 = first instruction fetched after a redirect
//   is_valid              instruction present this cycle
//   hold                  write stage cannot accept (driven by write stage)
interface i_execute_to_write;
    logic [31:0] pc;
    logic [31:0] adjustment;
    logic [31:0] destination_value;
    logic [7:0]  destination;
    logic [3:0]  flags;
    logic        destination_is_memory;
    logic        has_flushed;
    logic        is_valid;
    logic        hold;

    modport write_in (
        input  pc, adjustment, destination_value, destination, flags,
        input  destination_is_memory, has_flushed, is_valid,
        output hold
    );

    modport execute_out (
        output pc, adjustment, destination_value, destination, flags,
        output destination_is_memory, has_flushed, is_valid,
        input  hold
    );
endinterface

// File: rtl/write_stage.sv
// rtl/write_stage.sv - retire stage: register file, PC/flags update, store issue
//
// Retires instructions from execute into the architectural register file.
// Index NR-1 is Flags, NR-2 is PC, index 0 always reads zero.
// Optional feature macro: WRITE_STAGE_RETIRE_COUNT_EN adds the retired counter.
// Ports:
//   clock, reset_n   clock and asynchronous active-low reset
//   ew               instruction from execute (write_in modport), hold back
//   registers        architectural register file, to the read stage
//   is_pc_changing   one-cycle pulse when a retired instruction redirects PC
//   mem_address      store address
//   mem_data         store data
//   mem_write        store request, held until mem_ack
//   mem_ack          store acknowledge, only looked at while a store waits
//   retired          (macro only) count of processed instructions
module write_stage #(
    parameter int          NR       = 4,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          PC_STEP  = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    i_execute_to_write.write_in  ew,
    output logic [NR-1:0][31:0]  registers,
    output logic                 is_pc_changing,
    output logic [31:0]          mem_address,
    output logic [31:0]          mem_data,
    output logic                 mem_write,
    input  logic                 mem_ack
`ifdef WRITE_STAGE_RETIRE_COUNT_EN
    ,
    output logic [31:0]          retired
`endif
);

    localparam int PC_IDX    = NR - 2;
    localparam int FLAGS_IDX = NR - 1;

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] MEM_WAIT = 2'd1;
    localparam logic [1:0] DRAIN    = 2'd2;

    logic [1:0]  state;
    logic        hold;
    logic        accept;
    logic        process;
    logic        is_store;
    logic        is_branch;
    logic [31:0] store_base;

    // Hold is a pure function of state so execute never sees a
    // combinational path from its own is_valid back to hold.
    assign hold    = (state == MEM_WAIT);
    assign ew.hold = hold;

    assign accept    = ew.is_valid && !hold;
    // In DRAIN only the first post-redirect instruction is real work;
    // everything fetched down the wrong path is dropped.
    assign process   = accept && ((state != DRAIN) || ew.has_flushed);
    assign is_store  = ew.destination_is_memory;
    assign is_branch = !is_store && (ew.destination == 8'(PC_IDX));

    // Store base register; out-of-range indices and index 0 read as zero.
    always_comb begin
        store_base = '0;
        for (int i = 1; i < NR; i++) begin
            if (ew.destination == 8'(i)) begin
                store_base = registers[i];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            registers         <= '0;
            registers[PC_IDX] <= RESET_PC;
            state             <= RUN;
            is_pc_changing    <= 1'b0;
            mem_write         <= 1'b0;
            mem_address       <= '0;
            mem_data          <= '0;
`ifdef WRITE_STAGE_RETIRE_COUNT_EN
            retired           <= '0;
`endif
        end else begin
            is_pc_changing <= 1'b0;
            if (state == MEM_WAIT) begin
                if (mem_ack) begin
                    mem_write <= 1'b0;
                    state     <= RUN;
                end
            end else if (process) begin
`ifdef WRITE_STAGE_RETIRE_COUNT_EN
                retired <= retired + 32'd1;
`endif
                registers[FLAGS_IDX][3:0] <= ew.flags;
                if (is_branch) begin
                    registers[PC_IDX] <= ew.destination_value;
                    is_pc_changing    <= 1'b1;
                    state             <= DRAIN;
                end else begin
                    registers[PC_IDX] <= ew.pc + 32'(PC_STEP);
                    state             <= is_store ? MEM_WAIT : RUN;
                end
                if (is_store) begin
                    mem_address <= store_base + ew.adjustment;
                    mem_data    <= ew.destination_value;
                    mem_write   <= 1'b1;
                end
                // Full-word write issued after the flags nibble so an
                // explicit write to Flags wins over the flags update.
                for (int i = 1; i < NR; i++) begin
                    if (i != PC_IDX && !is_store && ew.destination == 8'(i)) begin
                        registers[i] <= ew.destination_value;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_write_stage.sv
// tb/tb_write_stage.sv - directed scoreboard bench for write_stage
module tb_write_stage;

    logic             clock = 1'b0;
    logic             reset_n;
    logic [3:0][31:0] registers;
    logic             is_pc_changing;
    logic [31:0]      mem_address;
    logic [31:0]      mem_data;
    logic             mem_write;
    logic             mem_ack;
`ifdef WRITE_STAGE_RETIRE_COUNT_EN
    logic [31:0]      retired;
`endif

    i_execute_to_write ew_if ();

    write_stage #(.NR(4), .RESET_PC(32'h0), .PC_STEP(4)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ew             (ew_if),
        .registers      (registers),
        .is_pc_changing (is_pc_changing),
        .mem_address    (mem_address),
        .mem_data       (mem_data),
        .mem_write      (mem_write),
        .mem_ack        (mem_ack)
`ifdef WRITE_STAGE_RETIRE_COUNT_EN
        ,
        .retired        (retired)
`endif
    );

    always #5 clock = ~clock;

    string       q_tag[$];
    logic [31:0] q_val[$];
    int          total  = 0;
    int          passed = 0;

    task automatic expect_val(input string tag, input logic [31:0] v);
        q_tag.push_back(tag);
        q_val.push_back(v);
    endtask

    task automatic check(input logic [31:0] obs);
        string       tag;
        logic [31:0] exp;
        total++;
        if (q_val.size() == 0) begin
            $error("FAIL scoreboard_underflow observed=%h expected=none", obs);
            return;
        end
        tag = q_tag.pop_front();
        exp = q_val.pop_front();
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic issue(input logic [7:0] dest, input logic [31:0] val,
                         input logic [31:0] pc, input logic [3:0] fl,
                         input logic mem, input logic [31:0] adj,
                         input logic flushed);
        ew_if.is_valid              = 1'b1;
        ew_if.destination           = dest;
        ew_if.destination_value     = val;
        ew_if.pc                    = pc;
        ew_if.flags                 = fl;
        ew_if.destination_is_memory = mem;
        ew_if.adjustment            = adj;
        ew_if.has_flushed           = flushed;
    endtask

    task automatic idle();
        ew_if.is_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        mem_ack = 1'b0;
        issue(8'd0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0);
        idle();
        tick();
        tick();
        // reset state
        expect_val("rst_pc", 32'h0);       expect_val("rst_r1", 32'h0);
        expect_val("rst_flags", 32'h0);    expect_val("rst_hold", 32'h0);
        expect_val("rst_mem_write", 32'h0); expect_val("rst_mem_addr", 32'h0);
        expect_val("rst_pc_changing", 32'h0);
        check(registers[2]); check(registers[1]); check(registers[3]);
        check(32'(ew_if.hold)); check(32'(mem_write)); check(mem_address);
        check(32'(is_pc_changing));
        reset_n = 1'b1;

        // basic register write
        issue(8'd1, 32'h12345678, 32'h100, 4'b0101, 1'b0, 32'h0, 1'b0);
        expect_val("w1_r1", 32'h12345678); expect_val("w1_pc", 32'h104);
        expect_val("w1_flags", 32'h5);
        tick(); idle();
        check(registers[1]); check(registers[2]); check(registers[3]);

        // write to register 0 discarded
        issue(8'd0, 32'hFFFFFFFF, 32'h104, 4'hA, 1'b0, 32'h0, 1'b0);
        expect_val("r0_zero", 32'h0); expect_val("r0_pc", 32'h108);
        expect_val("r0_r1_kept", 32'h12345678); expect_val("r0_flags", 32'hA);
        tick(); idle();
        check(registers[0]); check(registers[2]); check(registers[1]); check(registers[3]);

        // explicit Flags write overrides the flags nibble
        issue(8'd3, 32'hF0F0F0F0, 32'h108, 4'h5, 1'b0, 32'h0, 1'b0);
        expect_val("flagw_reg", 32'hF0F0F0F0); expect_val("flagw_pc", 32'h10C);
        tick(); idle();
        check(registers[3]); check(registers[2]);

        // out-of-range destination discarded, PC and flags still update
        issue(8'd5, 32'h1, 32'h10C, 4'h3, 1'b0, 32'h0, 1'b0);
        expect_val("oor_r1", 32'h12345678); expect_val("oor_pc", 32'h110);
        expect_val("oor_flags", 32'hF0F0F0F3);
        tick(); idle();
        check(registers[1]); check(registers[2]); check(registers[3]);

        // invalid cycles and a stray ack change nothing
        issue(8'd1, 32'hBAD, 32'h999, 4'hF, 1'b1, 32'h4, 1'b1);
        idle();
        mem_ack = 1'b1;
        expect_val("idle_pc", 32'h110); expect_val("idle_r1", 32'h12345678);
        expect_val("idle_mem_write", 32'h0); expect_val("idle_hold", 32'h0);
        tick(); tick();
        mem_ack = 1'b0;
        check(registers[2]); check(registers[1]); check(32'(mem_write)); check(32'(ew_if.hold));

        // set store base
        issue(8'd1, 32'h200, 32'h110, 4'h0, 1'b0, 32'h0, 1'b0);
        expect_val("base_r1", 32'h200); expect_val("base_pc", 32'h114);
        tick(); idle();
        check(registers[1]); check(registers[2]);

        // store, acked in the third cycle of hold
        issue(8'd1, 32'hAB, 32'h114, 4'h0, 1'b1, 32'h8, 1'b0);
        expect_val("st_mem_write", 32'h1); expect_val("st_addr", 32'h208);
        expect_val("st_data", 32'hAB);     expect_val("st_hold_c1", 32'h1);
        expect_val("st_pc", 32'h118);      expect_val("st_r1_kept", 32'h200);
        tick();
        check(32'(mem_write)); check(mem_address); check(mem_data);
        check(32'(ew_if.hold)); check(registers[2]); check(registers[1]);
        issue(8'd1, 32'hDEAD, 32'h118, 4'h0, 1'b0, 32'h0, 1'b0);
        expect_val("st_hold_c2", 32'h1); expect_val("st_addr_c2", 32'h208);
        expect_val("st_r1_stalled", 32'h200);
        tick();
        check(32'(ew_if.hold)); check(mem_address); check(registers[1]);
        mem_ack = 1'b1;
        #1;
        expect_val("st_hold_c3", 32'h1);
        check(32'(ew_if.hold));
        expect_val("ack_mem_write", 32'h0); expect_val("ack_hold", 32'h0);
        expect_val("ack_r1_not_taken", 32'h200);
        tick();
        mem_ack = 1'b0;
        check(32'(mem_write)); check(32'(ew_if.hold)); check(registers[1]);
        expect_val("post_st_r1", 32'hDEAD); expect_val("post_st_pc", 32'h11C);
        tick(); idle();
        check(registers[1]); check(registers[2]);

        // branch, two wrong-path instructions, then the flushed one
        issue(8'd2, 32'h400, 32'h11C, 4'h0, 1'b0, 32'h0, 1'b0);
        expect_val("br_pulse", 32'h1); expect_val("br_pc", 32'h400);
        tick();
        check(32'(is_pc_changing)); check(registers[2]);
        issue(8'd1, 32'h99, 32'h120, 4'hC, 1'b0, 32'h0, 1'b0);
        expect_val("dr1_pulse_off", 32'h0); expect_val("dr1_r1", 32'hDEAD);
        expect_val("dr1_pc", 32'h400);      expect_val("dr1_hold", 32'h0);
        tick();
        check(32'(is_pc_changing)); check(registers[1]); check(registers[2]); check(32'(ew_if.hold));
        issue(8'd1, 32'h99, 32'h124, 4'hC, 1'b0, 32'h0, 1'b0);
        expect_val("dr2_r1", 32'hDEAD); expect_val("dr2_pc", 32'h400);
        expect_val("dr2_flags", 32'hF0F0F0F0);
        tick();
        check(registers[1]); check(registers[2]); check(registers[3]);
        issue(8'd1, 32'h7, 32'h400, 4'h0, 1'b0, 32'h0, 1'b1);
        expect_val("fl_r1", 32'h7); expect_val("fl_pc", 32'h404);
        tick();
        check(registers[1]); check(registers[2]);
        issue(8'd1, 32'h8, 32'h404, 4'h0, 1'b0, 32'h0, 1'b0);
        expect_val("run_again_r1", 32'h8); expect_val("run_again_pc", 32'h408);
        tick(); idle();
        check(registers[1]); check(registers[2]);

        // PC wrap
        issue(8'd1, 32'h3, 32'hFFFFFFFC, 4'h0, 1'b0, 32'h0, 1'b0);
        expect_val("wrap_pc", 32'h0); expect_val("wrap_r1", 32'h3);
        tick(); idle();
        check(registers[2]); check(registers[1]);
`ifdef WRITE_STAGE_RETIRE_COUNT_EN
        expect_val("retired_count", 32'd11);
        check(retired);
`endif

        // reset while a store waits
        issue(8'd1, 32'h55, 32'h0, 4'h0, 1'b1, 32'h4, 1'b0);
        expect_val("st2_mem_write", 32'h1); expect_val("st2_addr", 32'h7);
        expect_val("st2_pc", 32'h4);
        tick(); idle();
        check(32'(mem_write)); check(mem_address); check(registers[2]);
        #2;
        reset_n = 1'b0;
        #1;
        expect_val("arst_mem_write", 32'h0); expect_val("arst_hold", 32'h0);
        expect_val("arst_pc", 32'h0);        expect_val("arst_r1", 32'h0);
        expect_val("arst_flags", 32'h0);     expect_val("arst_addr", 32'h0);
        expect_val("arst_data", 32'h0);
        check(32'(mem_write)); check(32'(ew_if.hold)); check(registers[2]);
        check(registers[1]); check(registers[3]); check(mem_address); check(mem_data);
`ifdef WRITE_STAGE_RETIRE_COUNT_EN
        expect_val("arst_retired", 32'h0);
        check(retired);
`endif
        tick();
        reset_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/write_stage.md
WRITE_STAGE -- requirements
Module: write_stage

Interface
REQ-001 SHALL have parameter NR, default 4, register-file depth; index NR-1 is Flags, NR-2 is PC, index 0 reads as zero.
REQ-002 SHALL have parameter RESET_PC, default 0, PC register value after reset.
REQ-003 SHALL have parameter PC_STEP, default 4, PC increment per retired non-branch instruction.
REQ-004 clock  in  1  sole clock; all state updates on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 ew  write_in modport of i_execute_to_write  --  pc, adjustment, destination_value, destination, flags, destination_is_memory, has_flushed, is_valid in; hold out.
REQ-007 registers  out  regfile_t  current architectural register file, to read stage.
REQ-008 is_pc_changing  out  1  one-cycle pulse when a retired instruction redirects PC.
REQ-009 mem_address, mem_data  out  32 each  store address and data.
REQ-010 mem_write  out  1  store request, held until acknowledged.
REQ-011 mem_ack  in  1  store acknowledge from memory.

Function
REQ-012 Instruction accepted when is_valid=1 and hold=0 at a rising edge; consumed same edge.
REQ-013 States: RUN, MEM_WAIT, DRAIN; reset state RUN.
REQ-014 RUN, accepted, destination_is_memory=0: registers[destination] <= destination_value next edge; latency one cycle to registers output.
REQ-015 Writes to destination 0 or destination >= NR discarded; registers[0] always reads 0.
REQ-016 Every accepted instruction sets registers[Flags][3:0] <= flags; a same-instruction write to Flags overrides this.
REQ-017 Accepted instruction with destination != PC: registers[PC] <= pc + PC_STEP (32-bit wrap, modulo 2^32).
REQ-018 Accepted instruction with destination == PC (register form): registers[PC] <= destination_value, is_pc_changing pulses one cycle, state -> DRAIN.
REQ-019 RUN, accepted, destination_is_memory=1: mem_address <= registers[destination] + adjustment (modulo 2^32), mem_data <= destination_value, mem_write <= 1, state -> MEM_WAIT; no register write except PC/Flags per REQ-016/017.
REQ-020 MEM_WAIT: hold=1, mem_write, mem_address, mem_data stable; on mem_ack=1 clear mem_write, state -> RUN, hold deasserts next cycle.
REQ-021 mem_ack sampled only in MEM_WAIT; ack in other states ignored.
REQ-022 DRAIN: hold=0; valid instructions with has_flushed=0 discarded with no state change; first valid with has_flushed=1 processed as in RUN and leaves DRAIN.
REQ-023 RUN/DRAIN: hold=0; hold depends on state only, never combinationally on is_valid.
REQ-024 is_valid=0 cycles: no architectural change.

Reset
REQ-025 reset_n=0, any state incl. MEM_WAIT: registers <= ZeroRegFile except registers[PC] <= RESET_PC; state RUN; hold=0, is_pc_changing=0, mem_write=0, mem_address=0, mem_data=0; pending store abandoned.
REQ-026 First acceptance no earlier than first rising edge after reset_n deasserts.

Configuration
REQ-027 WRITE_STAGE_RETIRE_COUNT_EN defined: add output retired (32 bits, reset 0), incremented per processed (non-discarded) instruction, wraps at 2^32; undefined: no port, no counter logic.

Verification
REQ-028 Reset then accept destination=1, value 0x12345678, pc 0x100, flags 4'b0101 -> next cycle registers[1]=0x12345678, registers[PC]=0x104, Flags[3:0]=0101.
REQ-029 Accept destination=0, value 0xFFFFFFFF -> registers[0] stays 0, PC advances by 4.
REQ-030 Store: registers[1]=0x200, destination=1, adjustment 8, destination_is_memory, value 0xAB -> mem_write=1, mem_address 0x208, mem_data 0xAB, hold=1 for 3 cycles until mem_ack on cycle 3, then hold=0.
REQ-031 Branch: destination=PC, value 0x400 -> is_pc_changing one pulse, PC=0x400; next two valid has_flushed=0 destination=1 discarded; has_flushed=1 destination=1 value 7 written, PC=pc+4.
REQ-032 Assert reset_n low during MEM_WAIT -> mem_write and hold drop immediately, PC=RESET_PC, other registers 0.
REQ-033 pc 0xFFFFFFFC non-branch -> PC wraps to 0x00000000; with WRITE_STAGE_RETIRE_COUNT_EN, retired equals processed count.
